// File: rtl/csr_pkg.sv
// Shared CSR address map, mcountinhibit bit positions and decode types for the
// performance-counter CSR file.
package csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE      = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_TIME       = 12'hC01;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET    = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH     = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_TIMEH      = 12'hC81;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH   = 12'hC82;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCOUNTINH  = 12'h320;
  localparam logic [CSR_ADDR_W-1:0] SCRATCH_BASE   = 12'h7C0;

  localparam int unsigned INH_CY = 0;
  localparam int unsigned INH_IR = 2;

  typedef enum logic [2:0] {
    TGT_CYCLE,
    TGT_TIME,
    TGT_INSTRET,
    TGT_INHIBIT,
    TGT_SCRATCH,
    TGT_NONE
  } csr_target_e;

  typedef struct packed {
    csr_target_e target;
    logic        hi;
  } csr_dec_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with half-word software writes; a write in a cycle replaces
// that half and cancels the increment for the whole counter.
module csr_counter64 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INC_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en,
  input  logic [INC_W-1:0]      inc_amt,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [63:0]           value
);

  logic [63:0] nxt_c;

  always_comb begin
    nxt_c = value;
    if (wr_lo || wr_hi) begin
      if (wr_lo) nxt_c[DATA_WIDTH-1:0] = wr_data;
      if (wr_hi) nxt_c[63:32]          = wr_data[31:0];
    end else if (inc_en) begin
      nxt_c = value + 64'(inc_amt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= nxt_c;
  end

endmodule

// File: rtl/csr_counter_file.sv
// Performance-counter CSR file: cycle/time/instret, mcountinhibit and scratch
// CSRs behind a one-cycle registered read port and a checked write port.
module csr_counter_file
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned RET_PORTS   = 2,
  parameter int unsigned TIME_DIV    = 1,
  parameter int unsigned NUM_SCRATCH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic [RET_PORTS-1:0]  ret_valid
);

  localparam int unsigned RET_W  = $clog2(RET_PORTS + 1);
  localparam int unsigned PRE_W  = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam int unsigned SCR_W  = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam bit          HAS_HI = (DATA_WIDTH == 32);

  // Shared by both ports; high halves only exist on a 32-bit datapath.
  function automatic csr_dec_t csr_decode(input logic [ADDR_WIDTH-1:0] a);
    csr_dec_t d;
    d.target = TGT_NONE;
    d.hi     = 1'b0;
    if (a == ADDR_WIDTH'(CSR_CYCLE) || a == ADDR_WIDTH'(CSR_MCYCLE)) begin
      d.target = TGT_CYCLE;
    end else if (a == ADDR_WIDTH'(CSR_TIME)) begin
      d.target = TGT_TIME;
    end else if (a == ADDR_WIDTH'(CSR_INSTRET) || a == ADDR_WIDTH'(CSR_MINSTRET)) begin
      d.target = TGT_INSTRET;
    end else if (HAS_HI && (a == ADDR_WIDTH'(CSR_CYCLEH) || a == ADDR_WIDTH'(CSR_MCYCLEH))) begin
      d.target = TGT_CYCLE;
      d.hi     = 1'b1;
    end else if (HAS_HI && a == ADDR_WIDTH'(CSR_TIMEH)) begin
      d.target = TGT_TIME;
      d.hi     = 1'b1;
    end else if (HAS_HI && (a == ADDR_WIDTH'(CSR_INSTRETH) || a == ADDR_WIDTH'(CSR_MINSTRETH))) begin
      d.target = TGT_INSTRET;
      d.hi     = 1'b1;
    end else if (a == ADDR_WIDTH'(CSR_MCOUNTINH)) begin
      d.target = TGT_INHIBIT;
    end else if ((a - ADDR_WIDTH'(SCRATCH_BASE)) < ADDR_WIDTH'(NUM_SCRATCH)) begin
      d.target = TGT_SCRATCH;
    end
    return d;
  endfunction

  function automatic logic [RET_W-1:0] popcount(input logic [RET_PORTS-1:0] v);
    logic [RET_W-1:0] n;
    n = '0;
    for (int i = 0; i < RET_PORTS; i++) n = n + RET_W'(v[i]);
    return n;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] half(input logic [63:0] v, input logic hi);
    return hi ? DATA_WIDTH'(v[63:32]) : v[DATA_WIDTH-1:0];
  endfunction

  csr_dec_t              rd_dec_c;
  csr_dec_t              wr_dec_c;
  logic                  wr_ok_c;
  logic                  tick_c;
  logic [RET_W-1:0]      ret_cnt_c;
  logic [DATA_WIDTH-1:0] rd_val_c;
  logic [PRE_W-1:0]      pre_q;
  logic                  inh_cy;
  logic                  inh_ir;
  logic [63:0]           cycle_q;
  logic [63:0]           time_q;
  logic [63:0]           instret_q;
  logic [DATA_WIDTH-1:0] scratch [NUM_SCRATCH];

  assign rd_dec_c  = csr_decode(rd_addr);
  assign wr_dec_c  = csr_decode(wr_addr);
  // Addresses with [11:10]==2'b11 are the read-only user views.
  assign wr_ok_c   = wr_en && (wr_dec_c.target != TGT_NONE) && (wr_addr[11:10] != 2'b11);
  assign tick_c    = (pre_q == PRE_W'(TIME_DIV - 1));
  assign ret_cnt_c = popcount(ret_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cy <= 1'b0;
      inh_ir <= 1'b0;
    end else if (wr_ok_c && wr_dec_c.target == TGT_INHIBIT) begin
      inh_cy <= wr_data[INH_CY];
      inh_ir <= wr_data[INH_IR];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (wr_ok_c && wr_dec_c.target == TGT_SCRATCH) begin
      scratch[wr_addr[SCR_W-1:0]] <= wr_data;
    end
  end

  csr_counter64 #(.DATA_WIDTH(DATA_WIDTH), .INC_W(1)) u_cycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (!inh_cy),
    .inc_amt (1'b1),
    .wr_lo   (wr_ok_c && wr_dec_c.target == TGT_CYCLE && !wr_dec_c.hi),
    .wr_hi   (wr_ok_c && wr_dec_c.target == TGT_CYCLE && wr_dec_c.hi),
    .wr_data (wr_data),
    .value   (cycle_q)
  );

  csr_counter64 #(.DATA_WIDTH(DATA_WIDTH), .INC_W(1)) u_time (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (tick_c),
    .inc_amt (1'b1),
    .wr_lo   (1'b0),
    .wr_hi   (1'b0),
    .wr_data ('0),
    .value   (time_q)
  );

  csr_counter64 #(.DATA_WIDTH(DATA_WIDTH), .INC_W(RET_W)) u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (!inh_ir),
    .inc_amt (ret_cnt_c),
    .wr_lo   (wr_ok_c && wr_dec_c.target == TGT_INSTRET && !wr_dec_c.hi),
    .wr_hi   (wr_ok_c && wr_dec_c.target == TGT_INSTRET && wr_dec_c.hi),
    .wr_data (wr_data),
    .value   (instret_q)
  );

  always_comb begin
    rd_val_c = '0;
    case (rd_dec_c.target)
      TGT_CYCLE:   rd_val_c = half(cycle_q, rd_dec_c.hi);
      TGT_TIME:    rd_val_c = half(time_q, rd_dec_c.hi);
      TGT_INSTRET: rd_val_c = half(instret_q, rd_dec_c.hi);
      TGT_INHIBIT: begin
        rd_val_c[INH_CY] = inh_cy;
        rd_val_c[INH_IR] = inh_ir;
      end
      TGT_SCRATCH: rd_val_c = scratch[rd_addr[SCR_W-1:0]];
      default:     rd_val_c = '0;
    endcase
  end

  // Response reflects state before the edge, so same-cycle writes are not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && (rd_dec_c.target == TGT_NONE);
      wr_err   <= wr_en && !wr_ok_c;
      if (rd_en) rd_data <= rd_val_c;
    end
  end

endmodule

// File: tb/tb_csr_counter_file.sv
// Scoreboard bench for csr_counter_file (32-bit data, 2 retire lanes, time/4).
module tb_csr_counter_file;

  localparam int unsigned TDIV = 4;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
  logic [1:0]  ret_valid;

  csr_counter_file #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (12),
    .RET_PORTS   (2),
    .TIME_DIV    (TDIV),
    .NUM_SCRATCH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .ret_valid (ret_valid)
  );

  typedef struct {
    logic [31:0]     data;
    logic            err;
    longint unsigned cyc;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  longint unsigned cyc = 0;

  logic [63:0] m_cycle, m_time, m_instret;
  int unsigned m_pre;
  logic        m_cy, m_ir;
  logic [31:0] m_scr [4];

  logic        ovr_valid;
  logic [31:0] ovr_data;
  logic        ovr_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle = '0; m_time = '0; m_instret = '0; m_pre = 0;
    m_cy = 1'b0; m_ir = 1'b0;
    for (int i = 0; i < 4; i++) m_scr[i] = '0;
  endtask

  function automatic logic writable(input logic [11:0] a);
    return a inside {12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h320,
                     12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3};
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    e = 1'b0;
    case (a)
      12'hC00, 12'hB00: d = m_cycle[31:0];
      12'hC80, 12'hB80: d = m_cycle[63:32];
      12'hC01:          d = m_time[31:0];
      12'hC81:          d = m_time[63:32];
      12'hC02, 12'hB02: d = m_instret[31:0];
      12'hC82, 12'hB82: d = m_instret[63:32];
      12'h320:          d = {29'd0, m_ir, 1'b0, m_cy};
      12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3: d = m_scr[a[1:0]];
      default: begin d = '0; e = 1'b1; end
    endcase
  endtask

  // Advance the reference state by one clock using the inputs now applied.
  task automatic model_step();
    logic ok, w_cy, w_ir;
    ok   = wr_en && writable(wr_addr);
    w_cy = ok && (wr_addr inside {12'hB00, 12'hB80});
    w_ir = ok && (wr_addr inside {12'hB02, 12'hB82});
    if (!w_cy && !m_cy) m_cycle = m_cycle + 64'd1;
    if (!w_ir && !m_ir) m_instret = m_instret + 64'($countones(ret_valid));
    if (m_pre == TDIV - 1) begin m_pre = 0; m_time = m_time + 64'd1; end
    else m_pre = m_pre + 1;
    if (ok) begin
      case (wr_addr)
        12'hB00: m_cycle[31:0]    = wr_data;
        12'hB80: m_cycle[63:32]   = wr_data;
        12'hB02: m_instret[31:0]  = wr_data;
        12'hB82: m_instret[63:32] = wr_data;
        12'h320: begin m_cy = wr_data[0]; m_ir = wr_data[2]; end
        default: m_scr[wr_addr[1:0]] = wr_data;
      endcase
    end
  endtask

  task automatic tick();
    logic [31:0] d;
    logic        e, exp_werr;
    exp_t        ent;
    if (rd_en) begin
      model_read(rd_addr, d, e);
      if (ovr_valid) begin d = ovr_data; e = ovr_err; end
      ent.data = d; ent.err = e; ent.cyc = cyc + 1;
      sb.push_back(ent);
    end
    exp_werr = wr_en && !writable(wr_addr);
    model_step();
    @(posedge clk);
    #1;
    check("wr_err", 64'(wr_err), 64'(exp_werr));
    rd_en = 1'b0; wr_en = 1'b0; ovr_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
  endtask

  task automatic rd(input logic [11:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
  endtask

  task automatic rd_exp(input logic [11:0] a, input logic [31:0] d, input logic e);
    rd_en = 1'b1; rd_addr = a;
    ovr_valid = 1'b1; ovr_data = d; ovr_err = e;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_rd_data"},  64'(rd_data),  64'd0);
    check({tag, "_rd_err"},   64'(rd_err),   64'd0);
    check({tag, "_wr_err"},   64'(wr_err),   64'd0);
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_spurious", 64'(rd_valid), 64'd0);
      end else begin
        exp_t ent;
        ent = sb.pop_front();
        check("rd_cyc",  64'(cyc),     64'(ent.cyc));
        check("rd_data", 64'(rd_data), 64'(ent.data));
        check("rd_err",  64'(rd_err),  64'(ent.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c0, i0, t0;
    logic [31:0] nxt;
    rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; ret_valid = '0; ovr_valid = 1'b0; ovr_data = '0; ovr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Cycle count after 10 idle clocks, then multi-lane retirement.
    repeat (10) tick();
    rd_exp(12'hC00, 32'd10, 1'b0);
    ret_valid = 2'b11; repeat (5) tick();
    ret_valid = 2'b01; repeat (3) tick();
    ret_valid = 2'b00;
    rd_exp(12'hC02, 32'd13, 1'b0);
    rd(12'hC82); rd(12'hB02); rd(12'hC01); rd(12'hC81); rd(12'hB00);

    // Inhibit CY and IR; time keeps running.
    ret_valid = 2'b11;
    wr(12'h320, 32'h5);
    c0 = m_cycle; i0 = m_instret; t0 = m_time;
    repeat (20) tick();
    ret_valid = 2'b00;
    rd_exp(12'hC01, t0[31:0] + 32'd5, 1'b0);
    rd_exp(12'hC00, c0[31:0], 1'b0);
    rd_exp(12'hC02, i0[31:0], 1'b0);
    rd_exp(12'h320, 32'h5, 1'b0);
    wr(12'h320, 32'hFFFF_FFFF);
    rd_exp(12'h320, 32'h5, 1'b0);
    wr(12'h320, 32'h0);
    rd(12'h320);

    // Carry into the high half and write-over-increment.
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_exp(12'hB80, 32'd1, 1'b0);
    rd_exp(12'hC00, 32'd1, 1'b0);
    wr(12'hB00, 32'h1234);
    rd_exp(12'hC00, 32'h1234, 1'b0);
    rd_exp(12'hC80, 32'd1, 1'b0);
    wr(12'hB80, 32'h7);
    rd(12'hC80); rd(12'hC00);
    ret_valid = 2'b11;
    wr(12'hB02, 32'hFFFF_FFFF);
    tick();
    ret_valid = 2'b00;
    rd_exp(12'hB82, 32'd1, 1'b0);
    rd_exp(12'hB02, 32'd1, 1'b0);

    // Access errors.
    c0 = m_cycle;
    wr(12'hC00, 32'hDEAD);
    nxt = c0[31:0] + 32'd1;
    rd_exp(12'hC00, nxt, 1'b0);
    wr(12'hC01, 32'h1); wr(12'hC80, 32'h1);
    rd_exp(12'h123, 32'd0, 1'b1);
    wr(12'h7C4, 32'h1);
    rd_exp(12'h7C4, 32'd0, 1'b1);
    rd(12'hC81);

    // Scratch: same-cycle read returns the old value.
    wr_en = 1'b1; wr_addr = 12'h7C1; wr_data = 32'hA5A5_A5A5;
    rd_exp(12'h7C1, 32'd0, 1'b0);
    rd_exp(12'h7C1, 32'hA5A5_A5A5, 1'b0);
    wr(12'h7C3, 32'h1);
    rd(12'h7C3); rd(12'h7C0);

    // Reset with a read in flight: response dropped, state cleared.
    tick();
    rd_en = 1'b1; rd_addr = 12'h7C1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst_n = 1'b1;
    model_reset();
    rd_exp(12'hC00, 32'd0, 1'b0);
    rd_exp(12'h7C1, 32'd0, 1'b0);
    rd_exp(12'h320, 32'd0, 1'b0);
    rd_exp(12'hC02, 32'd0, 1'b0);
    rd_exp(12'hC80, 32'd0, 1'b0);
    repeat (2) tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
